// File: rtl/number_bank.sv
// Target-pattern store for the memory game: load patterns, then clear them by guessing.
// Optional miss limit (loss after MAX_MISS misses) enabled by `define NUMBER_BANK_MISS_LIMIT_EN.
module number_bank #(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 10,
  parameter int AW       = 4,
  parameter int MAX_MISS = 3
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             we,
  input  logic [AW-1:0]    wn,
  input  logic [WIDTH-1:0] d,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw,
  output logic             exist,
  output logic             hit,
  output logic             miss,
  output logic [AW:0]      remaining,
  output logic             all_found,
  output logic             lose,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] led
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  function automatic logic [AW:0] popcnt(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_slot [DEPTH];
  logic [WIDTH-1:0] w_slot_nxt [DEPTH];
  logic [DEPTH-1:0] r_valid, w_valid_nxt;
  logic [DEPTH-1:0] w_match;
  logic [AW:0]      r_remaining;
  logic [WIDTH-1:0] r_led, w_led_nxt;
  logic             r_key_q;
  logic             r_hit, w_hit_nxt;
  logic             r_miss, w_miss_nxt;
  logic             r_all_found, w_af_nxt;
  logic             w_guess;
  logic             w_wr;

`ifdef NUMBER_BANK_MISS_LIMIT_EN
  localparam int MW = $clog2(MAX_MISS + 1);
  logic [MW-1:0] r_mcnt, w_mcnt_nxt;
  logic          r_lose, w_lose_nxt;
  assign lose = r_lose;
`else
  assign lose = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_match[i] = r_valid[i] && (r_slot[i] == sw) && (sw != '0);
  end

  assign w_guess   = r_key_q && !key_n;
  assign w_wr      = we && ({1'b0, wn} < DEPTH_C) && (d != '0);
  assign exist     = (r_state == S_PLAY) && (|w_match);
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign remaining = r_remaining;
  assign all_found = r_all_found;
  assign state     = r_state;
  assign led       = r_led;

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_led_nxt   = r_led;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    w_af_nxt    = r_all_found;
    for (int i = 0; i < DEPTH; i++) w_slot_nxt[i] = r_slot[i];
`ifdef NUMBER_BANK_MISS_LIMIT_EN
    w_lose_nxt = r_lose;
    w_mcnt_nxt = r_mcnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_led_nxt = '0;
        if (start) begin
          w_state_nxt = S_LOAD;
          w_valid_nxt = '0;
          for (int i = 0; i < DEPTH; i++) w_slot_nxt[i] = '0;
`ifdef NUMBER_BANK_MISS_LIMIT_EN
          w_mcnt_nxt = '0;
`endif
        end
      end
      S_LOAD: begin
        if (w_wr) begin
          w_led_nxt = d;
          for (int i = 0; i < DEPTH; i++) begin
            if (wn == i[AW-1:0]) begin
              w_slot_nxt[i]  = d;
              w_valid_nxt[i] = 1'b1;
            end
          end
        end
        // The start check sees the coincident write, so a same-cycle write counts.
        if (start && (popcnt(w_valid_nxt) != '0)) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (key_n) w_led_nxt = sw;
        if (start) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = '0;
          for (int i = 0; i < DEPTH; i++) w_slot_nxt[i] = '0;
        end else if (w_guess) begin
          if (|w_match) begin
            w_hit_nxt   = 1'b1;
            w_valid_nxt = r_valid & ~w_match;
            for (int i = 0; i < DEPTH; i++)
              if (w_match[i]) w_slot_nxt[i] = '0;
            if (popcnt(w_valid_nxt) == '0) begin
              w_state_nxt = S_DONE;
              w_af_nxt    = 1'b1;
            end
          end else begin
            w_miss_nxt = 1'b1;
`ifdef NUMBER_BANK_MISS_LIMIT_EN
            w_mcnt_nxt = r_mcnt + MW'(1);
            if (r_mcnt == MW'(MAX_MISS - 1)) begin
              w_state_nxt = S_DONE;
              w_lose_nxt  = 1'b1;
              w_af_nxt    = 1'b0;
            end
`endif
          end
        end
      end
      S_DONE: begin
        w_led_nxt = '1;
        if (start) begin
          w_state_nxt = S_LOAD;
          w_valid_nxt = '0;
          w_af_nxt    = 1'b0;
          for (int i = 0; i < DEPTH; i++) w_slot_nxt[i] = '0;
`ifdef NUMBER_BANK_MISS_LIMIT_EN
          w_lose_nxt = 1'b0;
          w_mcnt_nxt = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_remaining <= '0;
      r_led       <= '0;
      r_key_q     <= 1'b1;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_all_found <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_remaining <= popcnt(w_valid_nxt);
      r_led       <= w_led_nxt;
      r_key_q     <= key_n;
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_all_found <= w_af_nxt;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_slot_nxt[i];
    end
  end

`ifdef NUMBER_BANK_MISS_LIMIT_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_mcnt <= '0;
      r_lose <= 1'b0;
    end else begin
      r_mcnt <= w_mcnt_nxt;
      r_lose <= w_lose_nxt;
    end
  end
`endif

endmodule
